// File: rtl/keyscan_pkg.sv
// Shared types for the key matrix scanner: scan FSM states, default matrix
// geometry and the event record carried through the event queue.
package keyscan_pkg;

   typedef enum logic [0:0] {
      DRIVE   = 1'b0,
      PROCESS = 1'b1
   } scan_state_t;

   localparam int DEF_COLS  = 4;
   localparam int DEF_ROWS  = 4;
   localparam int KEY_COUNT = DEF_COLS * DEF_ROWS;
   localparam int KEY_IDX_W = $clog2(KEY_COUNT);

   // One queued key event. is_repeat marks an autorepeat press.
   typedef struct packed {
      logic [KEY_IDX_W-1:0] key;
      logic                 press;
      logic                 is_repeat;
   } key_evt_t;

endpackage

// File: rtl/keyscan_event_fifo.sv
// Small synchronous event FIFO with a registered head word.
// A push into an empty FIFO appears on dout one cycle later; a push while
// full is accepted only if the head is popped in the same cycle.
// DEPTH must be a power of two, at least 2.
module keyscan_event_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 6
) (
   input  logic         clk12MHz,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         rd_ready,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_left;
   logic [W-1:0]  dout_q, dout_d;
   logic          empty_q, empty_d;
   logic          pop, do_push;

   // Next-state: pointer/count bookkeeping and prefetch of the next head word.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      dout_d   = dout_q;
      pop      = !empty_q && rd_ready;
      do_push  = push && ((cnt_q != CNT_MAX) || pop);
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      cnt_left = cnt_q - CW'(pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      cnt_d = cnt_left + CW'(do_push);
      // With nothing left behind the old head, the new head is the incoming
      // word; otherwise it is the oldest stored entry.
      if (cnt_left == '0) begin
         if (do_push) begin
            dout_d = din;
         end
      end else begin
         dout_d = mem_q[rd_ptr_d];
      end
      empty_d = (cnt_d == '0);
   end

   // Storage and head registers.
   always_ff @(posedge clk12MHz or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         empty_q  <= 1'b1;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         empty_q  <= empty_d;
      end
   end

   assign dout  = dout_q;
   assign empty = empty_q;
   assign full  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/key_matrix_scanner.sv
// Key matrix scanner: strobes one active-low column at a time, samples the
// synchronised active-low rows, debounces every key and queues press/release
// events. Optional autorepeat is enabled with `define KEYSCAN_AUTOREPEAT_EN.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  DRIVE   | kcol[col] low, settle timer counting down; rows latched at 0
//  PROCESS | one key of the latched column debounced per cycle, ROWS cycles
module key_matrix_scanner
   import keyscan_pkg::*;
#(
   parameter int COLS               = DEF_COLS,
   parameter int ROWS               = DEF_ROWS,
   parameter int SETTLE_CYCLES      = 1200,
   parameter int DEBOUNCE_SCANS     = 4,
   parameter int FIFO_DEPTH         = 4,
   parameter int REPEAT_DELAY_SCANS = 48,
   parameter int REPEAT_RATE_SCANS  = 8
) (
   input  logic                          clk12MHz,
   input  logic                          rst_n,
   output logic [COLS-1:0]               kcol,
   input  logic [ROWS-1:0]               krow,
   output logic [COLS*ROWS-1:0]          keys,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [$clog2(COLS*ROWS)-1:0]  evt_key,
   output logic                          evt_press,
   output logic                          evt_repeat,
   output logic                          evt_overflow,
   input  logic                          ovf_clr
);

   localparam int NK  = COLS * ROWS;
   localparam int KIW = $clog2(NK);
   localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int TW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int EW  = $bits(key_evt_t);
   localparam logic [TW-1:0] TMR_LOAD = TW'(SETTLE_CYCLES - 1);
   localparam logic [3:0]    DB_TC    = 4'(DEBOUNCE_SCANS);

`ifdef KEYSCAN_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                            REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
   localparam int RPW     = $clog2(RPT_MAX + 1);
   localparam logic [RPW-1:0] RPT_DELAY = RPW'(REPEAT_DELAY_SCANS);
   localparam logic [RPW-1:0] RPT_RATE  = RPW'(REPEAT_RATE_SCANS);

   logic           rep_act_q, rep_act_d;
   logic [KIW-1:0] rep_key_q, rep_key_d;
   logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
`endif

   logic [ROWS-1:0] krow_meta_q, krow_sync_q;
   scan_state_t     state_q, state_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [ROWS-1:0] raw_q, raw_d;
   logic [NK-1:0]   keys_q, keys_d;
   logic [3:0]      db_q [NK];
   logic [3:0]      db_d [NK];
   logic [COLS-1:0] kcol_q, kcol_d;
   logic            ovf_q, ovf_d;

   logic [KIW-1:0]  kidx;
   logic [3:0]      db_inc;
   logic            flip;
   logic            ev_push;
   key_evt_t        ev;
   key_evt_t        head;
   logic [EW-1:0]   fifo_dout;
   logic            fifo_full, fifo_empty;

   assign kidx = KIW'(col_q) * KIW'(ROWS) + KIW'(row_q);

   // Scan sequencing, per-key debounce and event generation.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      tmr_d   = tmr_q;
      raw_d   = raw_q;
      keys_d  = keys_q;
      db_d    = db_q;
      flip    = 1'b0;
      ev_push = 1'b0;
      ev      = '0;
      db_inc  = db_q[kidx] + 4'd1;
`ifdef KEYSCAN_AUTOREPEAT_EN
      rep_act_d = rep_act_q;
      rep_key_d = rep_key_q;
      rep_cnt_d = rep_cnt_q;
`endif
      unique case (state_q)
         DRIVE: begin
            if (tmr_q == '0) begin
               raw_d   = ~krow_sync_q;
               row_d   = '0;
               state_d = PROCESS;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         PROCESS: begin
            if (raw_q[row_q] == keys_q[kidx]) begin
               db_d[kidx] = '0;
            end else if (db_inc == DB_TC) begin
               flip         = 1'b1;
               db_d[kidx]   = '0;
               keys_d[kidx] = ~keys_q[kidx];
               ev_push      = 1'b1;
               ev.key       = KEY_IDX_W'(kidx);
               ev.press     = ~keys_q[kidx];
            end else begin
               db_d[kidx] = db_inc;
            end
`ifdef KEYSCAN_AUTOREPEAT_EN
            // Repeat timing is stepped on the tracked key's own scan slot, so
            // a repeat push never collides with a debounce push.
            if (flip) begin
               if (!keys_q[kidx]) begin
                  rep_act_d = 1'b1;
                  rep_key_d = kidx;
                  rep_cnt_d = RPT_DELAY;
               end else if (rep_act_q && (rep_key_q == kidx)) begin
                  rep_act_d = 1'b0;
               end
            end else if (rep_act_q && (rep_key_q == kidx)) begin
               if (rep_cnt_q == RPW'(1)) begin
                  ev_push      = 1'b1;
                  ev.key       = KEY_IDX_W'(kidx);
                  ev.press     = 1'b1;
                  ev.is_repeat = 1'b1;
                  rep_cnt_d    = RPT_RATE;
               end else begin
                  rep_cnt_d = rep_cnt_q - RPW'(1);
               end
            end
`endif
            if (row_q == RW'(ROWS - 1)) begin
               row_d   = '0;
               state_d = DRIVE;
               tmr_d   = TMR_LOAD;
               col_d   = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
            end else begin
               row_d = row_q + RW'(1);
            end
         end
         default: state_d = DRIVE;
      endcase
      kcol_d = ~(COLS'(1) << col_d);
      // A new drop wins over a simultaneous clear.
      ovf_d  = (ev_push && fifo_full && !(evt_valid && evt_ready)) ||
               (ovf_q && !ovf_clr);
   end

   // Two-flop synchroniser for the asynchronous row senses.
   always_ff @(posedge clk12MHz or negedge rst_n) begin
      if (!rst_n) begin
         krow_meta_q <= '1;
         krow_sync_q <= '1;
      end else begin
         krow_meta_q <= krow;
         krow_sync_q <= krow_meta_q;
      end
   end

   // Scan FSM, debounce state and registered outputs.
   always_ff @(posedge clk12MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DRIVE;
         col_q   <= '0;
         row_q   <= '0;
         tmr_q   <= TMR_LOAD;
         raw_q   <= '0;
         keys_q  <= '0;
         for (int i = 0; i < NK; i++) begin
            db_q[i] <= '0;
         end
         kcol_q  <= '1;
         ovf_q   <= 1'b0;
`ifdef KEYSCAN_AUTOREPEAT_EN
         rep_act_q <= 1'b0;
         rep_key_q <= '0;
         rep_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         tmr_q   <= tmr_d;
         raw_q   <= raw_d;
         keys_q  <= keys_d;
         db_q    <= db_d;
         kcol_q  <= kcol_d;
         ovf_q   <= ovf_d;
`ifdef KEYSCAN_AUTOREPEAT_EN
         rep_act_q <= rep_act_d;
         rep_key_q <= rep_key_d;
         rep_cnt_q <= rep_cnt_d;
`endif
      end
   end

   keyscan_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk12MHz (clk12MHz),
      .rst_n    (rst_n),
      .push     (ev_push),
      .din      (ev),
      .rd_ready (evt_ready),
      .dout     (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign head         = fifo_dout;
   assign kcol         = kcol_q;
   assign keys         = keys_q;
   assign evt_valid    = !fifo_empty;
   assign evt_key      = KIW'(head.key);
   assign evt_press    = head.press;
   assign evt_overflow = ovf_q;
`ifdef KEYSCAN_AUTOREPEAT_EN
   assign evt_repeat   = head.is_repeat;
`else
   // Repeat flag is never set when pushed, but tie it off explicitly.
   assign evt_repeat   = 1'b0 & head.is_repeat;
`endif

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Self-checking bench for key_matrix_scanner with a scoreboard of expected
// events; the autorepeat section runs when KEYSCAN_AUTOREPEAT_EN is defined.
module tb_key_matrix_scanner;

   localparam int COLS  = 4;
   localparam int ROWS  = 4;
   localparam int SETTLE = 8;
   localparam int DB    = 3;
   localparam int DEPTH = 4;
   localparam int FRAME = COLS * (SETTLE + ROWS);

   logic        clk12MHz = 1'b0;
   logic        rst_n    = 1'b0;
   logic [3:0]  kcol;
   logic [3:0]  krow;
   logic [15:0] keys;
   logic        evt_valid;
   logic        evt_ready = 1'b1;
   logic [3:0]  evt_key;
   logic        evt_press;
   logic        evt_repeat;
   logic        evt_overflow;
   logic        ovf_clr = 1'b0;

   logic [15:0] pressed  = '0;
   logic [15:0] keys_exp = '0;
   logic [5:0]  sb [$];
   int          n_total = 0;
   int          n_bad   = 0;

   key_matrix_scanner #(
      .COLS               (COLS),
      .ROWS               (ROWS),
      .SETTLE_CYCLES      (SETTLE),
      .DEBOUNCE_SCANS     (DB),
      .FIFO_DEPTH         (DEPTH),
      .REPEAT_DELAY_SCANS (4),
      .REPEAT_RATE_SCANS  (2)
   ) dut (
      .clk12MHz     (clk12MHz),
      .rst_n        (rst_n),
      .kcol         (kcol),
      .krow         (krow),
      .keys         (keys),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_key      (evt_key),
      .evt_press    (evt_press),
      .evt_repeat   (evt_repeat),
      .evt_overflow (evt_overflow),
      .ovf_clr      (ovf_clr)
   );

   always #5 clk12MHz = ~clk12MHz;

   // Matrix model: a pressed key pulls its row low while its column is driven.
   always_comb begin
      krow = '1;
      for (int c = 0; c < COLS; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            if (pressed[c*ROWS+r] && !kcol[c]) krow[r] = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic expect_evt(input int k, input logic press, input logic rpt);
      logic [3:0] kk;
      kk = 4'(k);
      sb.push_back({kk, press, rpt});
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk12MHz);
      #1 evt_ready = v;
   endtask

   // Return at the first negedge of a new frame (column 0 just driven).
   task automatic frame_start();
      int n;
      n = 0;
      while (kcol !== 4'h7 && n < 4*FRAME) begin @(negedge clk12MHz); n++; end
      while (kcol !== 4'hE && n < 4*FRAME) begin @(negedge clk12MHz); n++; end
      chk("frame_sync", {28'd0, kcol}, 32'hE);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame_start();
   endtask

   // Scoreboard: every accepted event must be the oldest expected one.
   always @(negedge clk12MHz) begin
      if (rst_n && evt_valid && evt_ready) begin
         if (sb.size() == 0) begin
            chk("evt_unexpected", {26'd0, evt_key, evt_press, evt_repeat}, 32'h3F_FFFF);
         end else begin
            chk("evt", {26'd0, evt_key, evt_press, evt_repeat}, {26'd0, sb.pop_front()});
         end
      end
   end

   initial begin
      #(40000 * 10);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] seq [7];
      logic [3:0] val;
      int         len;
      int         n;
      seq = '{4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};

      // Reset state
      #12;
      chk("rst_kcol", {28'd0, kcol}, 32'hF);
      chk("rst_keys", {16'd0, keys}, 32'h0);
      chk("rst_valid", {31'd0, evt_valid}, 32'h0);
      chk("rst_head", {26'd0, evt_key, evt_press, evt_repeat}, 32'h0);
      chk("rst_ovf", {31'd0, evt_overflow}, 32'h0);
      @(negedge clk12MHz);
      rst_n = 1'b1;

      // Column strobe sequence and timing
      n = 0;
      while (kcol !== 4'hD && n < 4*FRAME) begin @(negedge clk12MHz); n++; end
      for (int s = 0; s < 7; s++) begin
         val = kcol;
         len = 0;
         do begin @(negedge clk12MHz); len++; end while (kcol == val && len < 100);
         chk("kcol_val", {28'd0, val}, {28'd0, seq[s]});
         chk("kcol_len", len, SETTLE + ROWS);
      end
      repeat (10*FRAME) @(negedge clk12MHz);
      chk("idle_keys", {16'd0, keys}, 32'h0);
      chk("idle_valid", {31'd0, evt_valid}, 32'h0);

      // Steady press/release of key 6 with latency boundary
      frame_start();
      pressed[6] = 1'b1;
      expect_evt(6, 1'b1, 1'b0);
      frames(2);
      chk("k6_not_yet", {31'd0, keys[6]}, 32'h0);
      frames(1);
      chk("k6_pressed", {16'd0, keys}, 32'h40);
      pressed[6] = 1'b0;
      expect_evt(6, 1'b0, 1'b0);
      frames(2);
      chk("k6_still", {31'd0, keys[6]}, 32'h1);
      frames(1);
      chk("k6_released", {16'd0, keys}, 32'h0);
      chk("sb_drained_1", sb.size(), 0);

      // Glitches shorter than the debounce window never flip the key
      for (int g = 0; g < 4; g++) begin
         frame_start();
         pressed[6] = 1'b1;
         frames(1);
         pressed[6] = 1'b0;
         frames(1);
      end
      pressed[6] = 1'b1;
      frames(2);
      pressed[6] = 1'b0;
      frames(4);
      chk("glitch_keys", {16'd0, keys}, 32'h0);
      chk("glitch_valid", {31'd0, evt_valid}, 32'h0);

      // Overflow: six presses while the consumer stalls
      set_ready(1'b0);
      for (int k = 0; k < 6; k++) begin
         frame_start();
         pressed[k] = 1'b1;
         keys_exp[k] = 1'b1;
         if (k < DEPTH) expect_evt(k, 1'b1, 1'b0);
         frames(3);
         if (k == DEPTH - 1) chk("ovf_before_drop", {31'd0, evt_overflow}, 32'h0);
      end
      chk("ovf_keys", {16'd0, keys}, {16'd0, keys_exp});
      chk("ovf_flag", {31'd0, evt_overflow}, 32'h1);
      chk("ovf_valid", {31'd0, evt_valid}, 32'h1);
      chk("ovf_head_hold", {26'd0, evt_key, evt_press, evt_repeat}, {26'd0, sb[0]});
      @(negedge clk12MHz);
      ovf_clr = 1'b1;
      @(negedge clk12MHz);
      ovf_clr = 1'b0;
      chk("ovf_cleared", {31'd0, evt_overflow}, 32'h0);
      chk("ovf_head_hold2", {26'd0, evt_key, evt_press, evt_repeat}, {26'd0, sb[0]});
      set_ready(1'b1);
      repeat (10) @(negedge clk12MHz);
      chk("ovf_drained", sb.size(), 0);
      chk("ovf_empty", {31'd0, evt_valid}, 32'h0);

      // Simultaneous release of keys 0..5 arrives in scan order
      frame_start();
      pressed = '0;
      keys_exp = '0;
      for (int k = 0; k < 6; k++) expect_evt(k, 1'b0, 1'b0);
      frames(4);
      chk("rel_keys", {16'd0, keys}, 32'h0);
      chk("rel_drained", sb.size(), 0);
      chk("rel_ovf", {31'd0, evt_overflow}, 32'h0);

      // Asynchronous reset mid-PROCESS with two events queued
      set_ready(1'b0);
      frame_start();
      pressed[10] = 1'b1;
      pressed[11] = 1'b1;
      expect_evt(10, 1'b1, 1'b0);
      expect_evt(11, 1'b1, 1'b0);
      frames(4);
      chk("pre_rst_keys", {16'd0, keys}, 32'h0C00);
      chk("pre_rst_head", {26'd0, evt_key, evt_press, evt_repeat}, {26'd0, sb[0]});
      n = 0;
      while (kcol !== 4'hB && n < 4*FRAME) begin @(negedge clk12MHz); n++; end
      repeat (SETTLE + 1) @(negedge clk12MHz);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_kcol", {28'd0, kcol}, 32'hF);
      chk("arst_keys", {16'd0, keys}, 32'h0);
      chk("arst_valid", {31'd0, evt_valid}, 32'h0);
      pressed = '0;
      sb.delete();
      repeat (3) @(negedge clk12MHz);
      rst_n = 1'b1;
      n = 0;
      while (kcol === 4'hF && n < 10) begin @(negedge clk12MHz); n++; end
      chk("restart_col0", {28'd0, kcol}, 32'hE);
      set_ready(1'b1);
      frames(5);
      chk("post_rst_keys", {16'd0, keys}, 32'h0);
      chk("post_rst_valid", {31'd0, evt_valid}, 32'h0);

`ifdef KEYSCAN_AUTOREPEAT_EN
      // Hold key 9: press at frame 2, repeats at 6,8,10,12, release at 13
      frame_start();
      pressed[9] = 1'b1;
      expect_evt(9, 1'b1, 1'b0);
      for (int r = 0; r < 4; r++) expect_evt(9, 1'b1, 1'b1);
      expect_evt(9, 1'b0, 1'b0);
      frames(11);
      pressed[9] = 1'b0;
      frames(6);
      chk("rpt_drained", sb.size(), 0);
      chk("rpt_keys", {16'd0, keys}, 32'h0);
`endif

      repeat (5) @(negedge clk12MHz);
      chk("final_sb", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
- Input-side counterpart of the LED matrix display driver: scans a COLS x ROWS key/button matrix by strobing columns and sampling rows.
- Debounces each key and publishes the debounced key bitmap as a flat vector, with the same bit layout as the display "video memory".
- Emits press/release events through a small valid/ready event queue consumed by top-level logic.

Parameters:
- COLS, 4, number of column strobes driven.
- ROWS, 4, number of row sense inputs.
- SETTLE_CYCLES, 1200, cycles a column is driven before its rows are sampled (100 us at 12 MHz). Minimum 4.
- DEBOUNCE_SCANS, 4, consecutive disagreeing scans before a key's state flips. Range 1..15.
- FIFO_DEPTH, 4, event queue depth. Power of two.
- REPEAT_DELAY_SCANS, 48, autorepeat initial delay in frames. Used only with the optional feature.
- REPEAT_RATE_SCANS, 8, autorepeat period in frames. Used only with the optional feature.

Ports:
- clk12MHz  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- kcol  out  COLS  column strobes, active-low; exactly one bit low while driving, all high otherwise.
- krow  in  ROWS  row senses, active-low (external pull-ups); asynchronous.
- keys  out  COLS*ROWS  debounced state, 1 = pressed; bit index = col*ROWS+row.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_key  out  $clog2(COLS*ROWS)  key index of the head event.
- evt_press  out  1  1 = press, 0 = release.
- evt_repeat  out  1  1 = autorepeat press. Constant 0 without the optional feature.
- evt_overflow  out  1  sticky: an event was dropped.
- ovf_clr  in  1  single-cycle pulse that clears evt_overflow.

Behaviour:
- Reset is asynchronous and active-low; the clock is clk12MHz.
- Reset values: kcol all 1; keys 0; evt_valid 0; evt_key 0; evt_press 0; evt_repeat 0; evt_overflow 0; all debounce counters 0; FIFO empty; FSM in DRIVE with col=0. Reset asserted mid-scan or mid-handshake discards everything immediately.
- krow passes through a 2-flop synchroniser before use.
- FSM DRIVE(col):
  - kcol[col]=0.
  - Counts SETTLE_CYCLES cycles.
  - On the last cycle, latches the synchronised row vector (inverted, 1 = pressed), then goes to PROCESS.
- FSM PROCESS(col):
  - Lasts exactly ROWS cycles, row = 0..ROWS-1, one key per cycle; kcol stays driven.
  - If raw == keys[k], the key's counter clears.
  - Otherwise the counter increments. On reaching DEBOUNCE_SCANS, keys[k] toggles, the counter clears, and an event {k, new state} is pushed.
  - After row ROWS-1: col wraps COLS-1 -> 0, and the FSM returns to DRIVE.
  - Frame length = COLS*(SETTLE_CYCLES+ROWS) cycles.
- Latency: a debounced change becomes visible at most DEBOUNCE_SCANS frames after the first stable sample. keys and the FIFO push update in the same cycle.
- Handshake:
  - The head event transfers when evt_valid && evt_ready.
  - evt_key, evt_press and evt_repeat hold stable while evt_valid=1 and evt_ready=0.
  - Event order is preserved.
  - FIFO output is registered: an event pushed into an empty FIFO is visible the next cycle.
- FIFO full:
  - Push with a simultaneous pop succeeds.
  - Push without a pop drops the new event and sets evt_overflow. keys still updates.
- evt_overflow clears on ovf_clr. If ovf_clr coincides with a new drop, the flag remains set.

Optional Feature:
- Macro: KEYSCAN_AUTOREPEAT_EN.
- With the macro:
  - The most recently pressed key is tracked.
  - After REPEAT_DELAY_SCANS frames held, and then every REPEAT_RATE_SCANS frames, a press event with evt_repeat=1 is pushed.
  - Release of that key, or a press of another key, restarts tracking.
  - Repeat events obey the same overflow rules.
- Without the macro: no repeat logic exists, and evt_repeat is tied to 0.

Decomposition:
- Package keyscan_pkg holds:
  - FSM state enum {DRIVE, PROCESS}.
  - KEY_COUNT and KEY_IDX_W localparams derived from COLS/ROWS.
  - The event struct {key, press, repeat}.
- One sub-module, keyscan_event_fifo: synchronous FIFO, depth FIFO_DEPTH, registered output, full/empty flags, plus push-when-full-with-pop handling.

Test Plan (SETTLE_CYCLES=8, ROWS=4, COLS=4, DEBOUNCE_SCANS=3, frame=48 cycles):
- Reset release, krow=4'hF -> kcol cycles E,D,B,7 each for 12 cycles; keys=0 and evt_valid=0 after 10 frames.
- Hold key 6 (krow[2] low during col 1) steady -> keys[6]=1 after the 3rd frame; one event {key=6, press=1}. Release -> {6,0} after 3 frames.
- Toggle key 6 with a 1-frame glitch, repeated -> keys stays 0 and no events.
- evt_ready=0, press/release keys 0..5 in sequence (6 events) -> first 4 queued in order; evt_overflow=1; pulse ovf_clr -> 0; draining yields the 4 events unchanged.
- Assert rst_n=0 mid-PROCESS with 2 events queued -> kcol=F, keys=0, evt_valid=0 asynchronously; scanning restarts at col 0.
- With KEYSCAN_AUTOREPEAT_EN, REPEAT_DELAY_SCANS=4, REPEAT_RATE_SCANS=2: hold key 9 -> press event, then repeat events 4 frames later and every 2 frames; release stops them.
